// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM with a registered command path.
// Optional MEM_ARB_LOCK_EN adds lock0/lock1 so an owner can hold the RAM across accesses.
module mem_port_arbiter #(
    parameter int AW     = 9,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic [1:0]    cmd0,
    input  logic [1:0]    cmd1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
`ifdef MEM_ARB_LOCK_EN
    input  logic          lock0,
    input  logic          lock1,
`endif
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [1:0]    mem_cmd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] write_data,
    input  logic [DW-1:0] read_data,
    output logic          busy,
    output logic          owner
);

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t     state;
    logic       prio;
    logic [2:0] cnt;
    logic       locked;
    logic       grant_valid;
    logic       grant_port;
    logic [1:0] raw_cmd;
    logic [1:0] grant_cmd;

    // While locked only the current owner may be granted; otherwise round-robin on prio.
    always_comb begin
        grant_valid = 1'b0;
        grant_port  = 1'b0;
        if (locked) begin
            grant_valid = owner ? req1 : req0;
            grant_port  = owner;
        end else if (req0 && req1) begin
            grant_valid = 1'b1;
            grant_port  = prio;
        end else if (req0 || req1) begin
            grant_valid = 1'b1;
            grant_port  = req1;
        end
        raw_cmd   = grant_port ? cmd1 : cmd0;
        grant_cmd = (raw_cmd == CMD_READ || raw_cmd == CMD_WRITE) ? raw_cmd : CMD_NONE;
    end

    assign busy = (state != IDLE);

`ifdef MEM_ARB_LOCK_EN
    logic lock_now;
    assign lock_now = owner ? lock1 : lock0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            locked <= 1'b0;
        end else if (state == ACK) begin
            locked <= lock_now;
        end
    end
`else
    assign locked = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            mem_cmd    <= CMD_NONE;
            mem_addr   <= '0;
            write_data <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            owner      <= 1'b0;
            prio       <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner      <= grant_port;
                        mem_cmd    <= grant_cmd;
                        mem_addr   <= grant_port ? addr1 : addr0;
                        write_data <= grant_port ? wdata1 : wdata0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_cmd <= CMD_NONE;
                    if (mem_cmd == CMD_READ) begin
                        cnt   <= 3'(RD_LAT);
                        state <= WAIT;
                    end else begin
                        ack0  <= ~owner;
                        ack1  <= owner;
                        state <= ACK;
                    end
                end
                WAIT: begin
                    if (cnt == 3'd1) begin
                        if (owner) begin
                            rdata1 <= read_data;
                        end else begin
                            rdata0 <= read_data;
                        end
                        ack0  <= ~owner;
                        ack1  <= owner;
                        state <= ACK;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ACK: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    state <= IDLE;
`ifdef MEM_ARB_LOCK_EN
                    // A locking owner keeps priority so the other port cannot slip in.
                    if (!lock_now) begin
                        prio <= ~owner;
                    end
`else
                    prio <= ~owner;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
